ifu32_fetch: RTL and testbench

//   Instruction fetch stage directly upstream of the IDU32 decoder.

---
 rtl/ifu32_fetch_if.sv | 26 ++
 rtl/ifu32_fetch.sv | 147 ++++++++++++++
 tb/tb_ifu32_fetch.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu32_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute-stage redirect,
// and the valid/ready channel into decode.
interface ifu32_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_err;

  modport master (
    output imem_req, imem_addr, out_valid, out_inst, out_pc, out_err,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_req, imem_addr, out_valid, out_inst, out_pc, out_err,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifu32_fetch.sv
// Single-outstanding instruction fetch stage: owns the PC, fetches one word at a time and
// hands {inst, pc, err} to decode; redirects squash any in-flight response.
module ifu32_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter bit          ALIGN_TRAP = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  ifu32_fetch_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, addr, addr_n, inst, inst_n, opc, opc_n;
  logic        req, req_n, vld, vld_n, err, err_n;
  logic        kill, kill_n, pend, pend_n;

  logic        trap;
  logic [31:0] rpc;
  logic        in_flight;

  assign trap = bus.redirect_valid & ALIGN_TRAP & (bus.redirect_pc[1:0] != 2'b00);
  assign rpc  = ALIGN_TRAP ? bus.redirect_pc : {bus.redirect_pc[31:2], 2'b00};
  // A response is still owed unless it is retiring in this very cycle.
  assign in_flight = ((state == REQ) & bus.imem_gnt) | ((state == WAIT) & ~bus.imem_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      req   <= 1'b0;
      addr  <= RESET_PC;
      vld   <= 1'b0;
      inst  <= '0;
      opc   <= RESET_PC;
      err   <= 1'b0;
      kill  <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      req   <= req_n;
      addr  <= addr_n;
      vld   <= vld_n;
      inst  <= inst_n;
      opc   <= opc_n;
      err   <= err_n;
      kill  <= kill_n;
      pend  <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = req;
    addr_n  = addr;
    vld_n   = vld;
    inst_n  = inst;
    opc_n   = opc;
    err_n   = err;
    kill_n  = kill;
    pend_n  = pend;
    if (bus.redirect_valid) begin
      pc_n = rpc;
      if (in_flight) begin
        state_n = WAIT;
        req_n   = 1'b0;
        vld_n   = 1'b0;
        kill_n  = 1'b1;
        pend_n  = trap;
      end else begin
        kill_n = 1'b0;
        pend_n = 1'b0;
        if (trap) begin
          state_n = HOLD;
          req_n   = 1'b0;
          vld_n   = 1'b1;
          inst_n  = '0;
          opc_n   = bus.redirect_pc;
          err_n   = 1'b1;
        end else begin
          state_n = REQ;
          req_n   = 1'b1;
          addr_n  = rpc;
          vld_n   = 1'b0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          state_n = REQ;
          req_n   = 1'b1;
          addr_n  = pc;
        end
        REQ: if (bus.imem_gnt) begin
          state_n = WAIT;
          req_n   = 1'b0;
        end
        WAIT: if (bus.imem_rvalid) begin
          if (kill) begin
            kill_n = 1'b0;
            pend_n = 1'b0;
            // Squashed response drained; present a deferred alignment fault or refetch.
            if (pend) begin
              state_n = HOLD;
              vld_n   = 1'b1;
              inst_n  = '0;
              opc_n   = pc;
              err_n   = 1'b1;
            end else begin
              state_n = REQ;
              req_n   = 1'b1;
              addr_n  = pc;
            end
          end else begin
            state_n = HOLD;
            vld_n   = 1'b1;
            inst_n  = bus.imem_err ? 32'h0 : bus.imem_rdata;
            opc_n   = pc;
            err_n   = bus.imem_err;
          end
        end
        HOLD: if (vld & bus.out_ready) begin
          vld_n = 1'b0;
          if (err) begin
            state_n = HALT;
          end else begin
            state_n = REQ;
            pc_n    = pc + 32'd4;
            req_n   = 1'b1;
            addr_n  = pc + 32'd4;
          end
        end
        HALT: ;
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.out_valid = vld;
  assign bus.out_inst  = inst;
  assign bus.out_pc    = opc;
  assign bus.out_err   = err;
endmodule

// File: tb/tb_ifu32_fetch.sv
// Directed bring-up of the fetch stage followed by a randomized run checked against an
// architectural model: the decode stream must be memory contents at pc, pc+4, ... per redirect.
module tb_ifu32_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu32_fetch_if bus ();
  ifu32_fetch_if bus1 ();

  ifu32_fetch #(.RESET_PC(32'h8000_0000), .ALIGN_TRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master));
  ifu32_fetch #(.RESET_PC(32'h8000_0000), .ALIGN_TRAP(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.master));

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      tick;
      n++;
    end
    chk("req_up", bus.imem_req, 1);
    chk("req_addr", bus.imem_addr, a);
  endtask

  task automatic serve(input logic [31:0] d, input logic e);
    bus.imem_gnt = 1'b1;
    tick;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = d;
    bus.imem_err    = e;
    tick;
    bus.imem_rvalid = 1'b0;
    bus.imem_err    = 1'b0;
  endtask

  task automatic present(input logic [31:0] p, input logic [31:0] i, input logic e);
    chk("out_valid", bus.out_valid, 1);
    chk("out_pc", bus.out_pc, p);
    chk("out_inst", bus.out_inst, i);
    chk("out_err", bus.out_err, e);
  endtask

  task automatic accept;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk("valid_drop", bus.out_valid, 0);
  endtask

  task automatic redirect(input logic [31:0] p);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = p;
    tick;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic chk_reset_vals;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 32'h8000_0000);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_inst", bus.out_inst, 0);
    chk("rst_pc", bus.out_pc, 32'h8000_0000);
    chk("rst_err", bus.out_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        out_st, hold_chk, redir;
    int          cnt, xfers, idle;
    logic [31:0] oaddr, exp_pc, prev_addr, tgt;

    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.imem_err = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0; bus.out_ready = 0;
    bus1.imem_gnt = 0; bus1.imem_rvalid = 0; bus1.imem_rdata = 0; bus1.imem_err = 0;
    bus1.redirect_valid = 0; bus1.redirect_pc = 0; bus1.out_ready = 0;

    // reset state and first fetch
    repeat (2) tick;
    chk_reset_vals;
    rst_n = 1'b1;
    tick;
    chk("first_req", bus.imem_req, 1);
    chk("first_addr", bus.imem_addr, 32'h8000_0000);
    serve(32'h0050_0093, 1'b0);
    present(32'h8000_0000, 32'h0050_0093, 1'b0);

    // back-pressure on the second of three fetches
    accept;
    wait_req(32'h8000_0004);
    serve(memf(32'h8000_0004), 1'b0);
    repeat (5) begin
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_pc", bus.out_pc, 32'h8000_0004);
      chk("bp_noreq", bus.imem_req, 0);
      tick;
    end
    present(32'h8000_0004, memf(32'h8000_0004), 1'b0);
    accept;
    wait_req(32'h8000_0008);
    serve(memf(32'h8000_0008), 1'b0);
    present(32'h8000_0008, memf(32'h8000_0008), 1'b0);
    accept;

    // redirect during WAIT squashes the in-flight word
    wait_req(32'h8000_000C);
    bus.imem_gnt = 1'b1;
    tick;
    bus.imem_gnt = 1'b0;
    redirect(32'h8000_0100);
    chk("kill_valid", bus.out_valid, 0);
    chk("kill_noreq", bus.imem_req, 0);
    tick;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick;
    bus.imem_rvalid = 1'b0;
    chk("squash_valid", bus.out_valid, 0);
    chk("refetch_req", bus.imem_req, 1);
    chk("refetch_addr", bus.imem_addr, 32'h8000_0100);
    serve(memf(32'h8000_0100), 1'b0);
    present(32'h8000_0100, memf(32'h8000_0100), 1'b0);
    accept;
    // redirect coincident with rvalid
    bus.imem_gnt = 1'b1;
    tick;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b1;
    bus.imem_rdata     = 32'hDEAD_BEEF;
    redirect(32'h8000_0200);
    bus.imem_rvalid = 1'b0;
    chk("coinc_valid", bus.out_valid, 0);
    chk("coinc_req", bus.imem_req, 1);
    chk("coinc_addr", bus.imem_addr, 32'h8000_0200);

    // redirect while REQ is ungranted retargets, then a bus error halts fetch
    redirect(32'h8000_0010);
    chk("retgt_req", bus.imem_req, 1);
    chk("retgt_addr", bus.imem_addr, 32'h8000_0010);
    serve(32'hCAFE_F00D, 1'b1);
    present(32'h8000_0010, 32'h0, 1'b1);
    accept;
    repeat (6) begin
      chk("halt_noreq", bus.imem_req, 0);
      tick;
    end
    redirect(32'h8000_0000);
    chk("resume_addr", bus.imem_addr, 32'h8000_0000);
    serve(memf(32'h8000_0000), 1'b0);
    present(32'h8000_0000, memf(32'h8000_0000), 1'b0);
    accept;

    // misaligned redirect from HOLD traps without fetching
    serve(memf(32'h8000_0004), 1'b0);
    present(32'h8000_0004, memf(32'h8000_0004), 1'b0);
    redirect(32'h8000_0002);
    present(32'h8000_0002, 32'h0, 1'b1);
    repeat (3) begin
      chk("trap_noreq", bus.imem_req, 0);
      tick;
    end
    accept;
    repeat (3) begin
      chk("trap_halt", bus.imem_req, 0);
      tick;
    end
    // misaligned redirect while a response is owed: drained first, then the fault
    redirect(32'h8000_0020);
    chk("pend_addr", bus.imem_addr, 32'h8000_0020);
    bus.imem_gnt = 1'b1;
    tick;
    bus.imem_gnt = 1'b0;
    redirect(32'h8000_0007);
    chk("pend_valid0", bus.out_valid, 0);
    tick;
    chk("pend_valid1", bus.out_valid, 0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = memf(32'h8000_0020);
    tick;
    bus.imem_rvalid = 1'b0;
    present(32'h8000_0007, 32'h0, 1'b1);
    chk("pend_noreq", bus.imem_req, 0);
    accept;
    // ALIGN_TRAP=0 instance masks the low bits instead
    bus1.redirect_valid = 1'b1;
    bus1.redirect_pc    = 32'h8000_0046;
    tick;
    chk("na_addr0", bus1.imem_addr, 32'h8000_0044);
    bus1.redirect_pc = 32'h8000_0002;
    tick;
    bus1.redirect_valid = 1'b0;
    chk("na_req", bus1.imem_req, 1);
    chk("na_addr1", bus1.imem_addr, 32'h8000_0000);
    chk("na_valid", bus1.out_valid, 0);

    // PC wrap and asynchronous reset mid-fetch
    redirect(32'hFFFF_FFFC);
    chk("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
    serve(memf(32'hFFFF_FFFC), 1'b0);
    present(32'hFFFF_FFFC, memf(32'hFFFF_FFFC), 1'b0);
    accept;
    chk("wrap_req", bus.imem_req, 1);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    bus.imem_gnt = 1'b1;
    tick;
    bus.imem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_BAD0;
    tick;
    rst_n = 1'b1;
    tick;
    chk("late_valid0", bus.out_valid, 0);
    chk("late_req", bus.imem_req, 1);
    tick;
    bus.imem_rvalid = 1'b0;
    chk("late_valid1", bus.out_valid, 0);
    chk("late_addr", bus.imem_addr, 32'h8000_0000);

    // randomized run against the architectural stream model
    out_st = 0; hold_chk = 0; cnt = 0; xfers = 0; idle = 0;
    oaddr = 0; prev_addr = 0; exp_pc = 32'h8000_0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold_chk) begin
        chk("req_hold", bus.imem_req, 1);
        chk("addr_hold", bus.imem_addr, prev_addr);
      end
      bus.out_ready = ($urandom % 4) != 0;
      redir = ($urandom % 40) == 0;
      tgt = (($urandom % 8) == 0) ? 32'hFFFF_FFF0 + 32'(($urandom % 4) * 4)
                                  : 32'h8000_0000 + 32'($urandom_range(0, 63) * 4);
      bus.redirect_valid = redir;
      bus.redirect_pc    = tgt;
      bus.imem_gnt       = ($urandom % 3) != 0;
      if (out_st && cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = memf(oaddr);
        bus.imem_err    = 1'b0;
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        bus.imem_err    = 1'($urandom % 2);
        if (out_st) cnt--;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("rnd_pc", bus.out_pc, exp_pc);
        chk("rnd_inst", bus.out_inst, memf(exp_pc));
        chk("rnd_err", bus.out_err, 0);
        exp_pc = exp_pc + 32'd4;
        xfers++;
        idle = 0;
      end else begin
        idle++;
      end
      if (redir) exp_pc = tgt;
      hold_chk  = bus.imem_req && !bus.imem_gnt && !redir;
      prev_addr = bus.imem_addr;
      if (bus.imem_rvalid) out_st = 0;
      if (bus.imem_req && bus.imem_gnt) begin
        chk("rnd_align", {30'b0, bus.imem_addr[1:0]}, 0);
        out_st = 1;
        oaddr  = bus.imem_addr;
        cnt    = $urandom_range(0, 3);
      end
      if (idle > 200) begin
        chk("rnd_progress", idle, 0);
        break;
      end
      tick;
    end
    bus.redirect_valid = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_gnt       = 1'b0;
    chk("rnd_xfers", 32'(xfers >= 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
